// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and strobes from a hsync/vsync/video_on stream,
// measures line/frame periods and tracks timing lock.
//   state    | meaning
//   UNLOCKED | waiting for the first vsync fall
//   ACQUIRE  | counting consecutive clean frames
//   LOCKED   | timing stable, any error drops back to ACQUIRE
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_on_in,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       pix_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_total_meas,
  output logic [9:0] v_total_meas,
  output logic       h_err,
  output logic       v_err,
  output logic       locked
);

  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [9:0]  CNT_PRE = 10'd1022;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_t;

  logic        hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d;
  logic        h_fall, v_fall, vid_rise, vid_fall;
  logic [9:0]  h_cnt, v_lcnt;
  logic [10:0] h_cnt_inc;
  logic        hmeas_ok, vmeas_ok, v_fall_r;
  lock_state_t state;
  logic [3:0]  good_cnt, good_cnt_inc;
  logic        frame_bad, any_err;

  assign h_fall       = hsync_d & ~hsync_q;
  assign v_fall       = vsync_d & ~vsync_q;
  assign vid_rise     = video_q & ~video_d;
  assign vid_fall     = video_d & ~video_q;
  assign h_cnt_inc    = {1'b0, h_cnt} + 11'd1;
  assign good_cnt_inc = good_cnt + 4'd1;
  assign any_err      = h_err | v_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q <= 1'b0;
      hsync_d <= 1'b0;
      vsync_q <= 1'b0;
      vsync_d <= 1'b0;
      video_q <= 1'b0;
      video_d <= 1'b0;
    end else begin
      hsync_q <= hsync_in;
      hsync_d <= hsync_q;
      vsync_q <= vsync_in;
      vsync_d <= vsync_q;
      video_q <= video_on_in;
      video_d <= video_q;
    end
  end

  // First fall after reset only arms the comparison; timeout fires once on reaching saturation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt        <= '0;
      h_total_meas <= '0;
      hmeas_ok     <= 1'b0;
      h_err        <= 1'b0;
    end else if (h_fall) begin
      h_total_meas <= (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt_inc[9:0];
      h_cnt        <= '0;
      hmeas_ok     <= 1'b1;
      h_err        <= hmeas_ok && (h_cnt_inc != H_TOT);
    end else begin
      if (h_cnt != CNT_MAX) begin
        h_cnt <= h_cnt + 10'd1;
      end
      h_err <= (h_cnt == CNT_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_lcnt       <= '0;
      v_total_meas <= '0;
      vmeas_ok     <= 1'b0;
      v_err        <= 1'b0;
      v_fall_r     <= 1'b0;
    end else begin
      v_fall_r <= v_fall;
      if (v_fall) begin
        v_total_meas <= v_lcnt;
        v_lcnt       <= h_fall ? 10'd1 : 10'd0;
        vmeas_ok     <= 1'b1;
        v_err        <= vmeas_ok && (v_lcnt != V_TOT);
      end else begin
        if (h_fall && (v_lcnt != CNT_MAX)) begin
          v_lcnt <= v_lcnt + 10'd1;
        end
        v_err <= h_fall && (v_lcnt == CNT_PRE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out       <= '0;
      y_out       <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= video_q;
      line_start  <= vid_rise;
      frame_start <= vid_rise && (y_out == 10'd0);
      if (vid_rise) begin
        x_out <= '0;
      end else if (video_q && (x_out != CNT_MAX)) begin
        x_out <= x_out + 10'd1;
      end
      if (v_fall) begin
        y_out <= '0;
      end else if (vid_fall && (y_out != CNT_MAX)) begin
        y_out <= y_out + 10'd1;
      end
    end
  end

  // Reacts to the registered error pulses, so locked falls the clock after h_err/v_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= UNLOCKED;
      good_cnt  <= '0;
      frame_bad <= 1'b0;
      locked    <= 1'b0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (v_fall_r) begin
            state     <= ACQUIRE;
            good_cnt  <= '0;
            frame_bad <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (any_err) begin
            good_cnt  <= '0;
            frame_bad <= ~v_fall_r;
          end else if (v_fall_r) begin
            frame_bad <= 1'b0;
            if (!frame_bad) begin
              good_cnt <= good_cnt_inc;
              if (good_cnt_inc >= LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (any_err) begin
            state     <= ACQUIRE;
            locked    <= 1'b0;
            good_cnt  <= '0;
            frame_bad <= ~v_fall_r;
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: a raster source drives the DUT and
// queues expected coordinates/strobes, compared two clocks later.
module tb_vga_sync_decoder;

  localparam int H        = 160;
  localparam int V        = 16;
  localparam int H_VIS    = 128;
  localparam int HS_START = 136;
  localparam int HS_END   = 152;
  localparam int V_VIS    = 12;
  localparam int VS_START = 13;
  localparam int VS_END   = 15;
  localparam int FRAME    = H * V;

  logic       clk, rst;
  logic       hsync_in, vsync_in, video_on_in;
  logic [9:0] x_out, y_out, h_total_meas, v_total_meas;
  logic       pix_valid, line_start, frame_start, h_err, v_err, locked;

  vga_sync_decoder #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .x_out(x_out), .y_out(y_out), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .h_err(h_err), .v_err(v_err), .locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       pv;
    logic       ls;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  h_err_cnt = 0, v_err_cnt = 0, ls_cnt = 0;
  int  hs_fall_cnt = 0, vs_fall_cnt = 0;
  int  stretch_req = 0, stretch_done = 0, short_req = 0, short_done = 0;
  int  hc = 0, vc = 0, h_len = H, v_len = V;
  bit  gen_run = 0, chk_pv = 0, chk_xy = 0, hs_force = 0, vid_force = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raster source
  initial begin
    logic vid, hs, vs, vid_prev, hs_prev, vs_prev;
    exp_t e;
    hsync_in = 1'b1; vsync_in = 1'b1; video_on_in = 1'b0;
    vid_prev = 1'b0; hs_prev = 1'b1; vs_prev = 1'b1;
    wait (gen_run);
    forever begin
      @(posedge clk);
      #1;
      if (hc == 0) begin
        h_len = H;
        if (vc == 2 && stretch_req != stretch_done) begin
          h_len = H + 1;
          stretch_done++;
        end
        if (vc == 0) begin
          v_len = V;
          if (short_req != short_done) begin
            v_len = V - 1;
            short_done++;
          end
        end
      end
      vid = ((hc < H_VIS) && (vc < V_VIS)) || vid_force;
      hs  = !((hc >= HS_START) && (hc < HS_END)) || hs_force;
      vs  = !((vc >= VS_START) && (vc < VS_END));
      hsync_in = hs; vsync_in = vs; video_on_in = vid;
      e.pv = vid;
      e.ls = vid && !vid_prev;
      e.fs = vid && !vid_prev && (vc == 0);
      e.x  = 10'(hc);
      e.y  = 10'(vc);
      exp_q.push_back(e);
      if (hs_prev && !hs) hs_fall_cnt++;
      if (vs_prev && !vs) vs_fall_cnt++;
      vid_prev = vid; hs_prev = hs; vs_prev = vs;
      hc++;
      if (hc >= h_len) begin
        hc = 0;
        vc++;
        if (vc >= v_len) vc = 0;
      end
    end
  end

  // Scoreboard: the entry pushed two clocks ago matches the current outputs.
  always @(negedge clk) begin
    h_err_cnt = h_err_cnt + int'(h_err);
    v_err_cnt = v_err_cnt + int'(v_err);
    ls_cnt    = ls_cnt + int'(line_start);
    if (exp_q.size() == 3) begin
      mon_e = exp_q.pop_front();
      if (chk_pv) begin
        check("pix_valid", 64'(pix_valid), 64'(mon_e.pv));
        check("line_start", 64'(line_start), 64'(mon_e.ls));
      end
      if (chk_xy) begin
        check("frame_start", 64'(frame_start), 64'(mon_e.fs));
        if (mon_e.pv) begin
          check("x_out", 64'(x_out), 64'(mon_e.x));
          check("y_out", 64'(y_out), 64'(mon_e.y));
        end
      end
    end
  end

  task automatic wait_vfalls(input int n, input string tag);
    int target;
    target = vs_fall_cnt + n;
    for (int i = 0; i < 4 * FRAME * n && vs_fall_cnt < target; i++) @(posedge clk);
    check(tag, 64'(vs_fall_cnt >= target), 64'd1);
  endtask

  task automatic wait_hfalls(input int n, input string tag);
    int target;
    target = hs_fall_cnt + n;
    for (int i = 0; i < 4 * H * n && hs_fall_cnt < target; i++) @(posedge clk);
    check(tag, 64'(hs_fall_cnt >= target), 64'd1);
  endtask

  task automatic wait_err(input bit vert, input int base, input string tag);
    for (int i = 0; i < 3 * FRAME && (vert ? v_err_cnt : h_err_cnt) <= base; i++) @(posedge clk);
    check(tag, 64'((vert ? v_err_cnt : h_err_cnt) > base), 64'd1);
  endtask

  initial begin
    int e0, l0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({x_out, y_out, pix_valid, line_start, frame_start,
                                h_total_meas, v_total_meas, h_err, v_err, locked}), 64'd0);
    rst = 1'b1;
    gen_run = 1; chk_pv = 1; chk_xy = 1;

    // nominal stream: lock at the third vsync fall
    wait_vfalls(2, "t1_vfall2_timeout");
    repeat (5) @(negedge clk);
    check("t1_locked_before", 64'(locked), 64'd0);
    wait_vfalls(1, "t1_vfall3_timeout");
    repeat (5) @(negedge clk);
    check("t1_locked", 64'(locked), 64'd1);
    check("t1_h_meas", 64'(h_total_meas), 64'(H));
    check("t1_v_meas", 64'(v_total_meas), 64'(V));
    check("t1_no_h_err", 64'(h_err_cnt), 64'd0);
    check("t1_no_v_err", 64'(v_err_cnt), 64'd0);

    // one stretched line
    e0 = h_err_cnt;
    stretch_req++;
    wait_err(0, e0, "t2_h_err_timeout");
    @(negedge clk);
    check("t2_h_meas", 64'(h_total_meas), 64'(H + 1));
    check("t2_locked_drop", 64'(locked), 64'd0);
    wait_vfalls(2, "t2_vfall_timeout");
    repeat (5) @(negedge clk);
    check("t2_locked_mid", 64'(locked), 64'd0);
    wait_vfalls(1, "t2_vfall3_timeout");
    repeat (5) @(negedge clk);
    check("t2_relocked", 64'(locked), 64'd1);
    check("t2_h_err_once", 64'(h_err_cnt - e0), 64'd1);
    check("t2_h_meas_back", 64'(h_total_meas), 64'(H));

    // one short frame
    e0 = v_err_cnt;
    l0 = h_err_cnt;
    short_req++;
    wait_err(1, e0, "t3_v_err_timeout");
    @(negedge clk);
    check("t3_v_meas", 64'(v_total_meas), 64'(V - 1));
    check("t3_locked_drop", 64'(locked), 64'd0);
    wait_vfalls(2, "t3_vfall_timeout");
    repeat (5) @(negedge clk);
    check("t3_relocked", 64'(locked), 64'd1);
    check("t3_v_err_once", 64'(v_err_cnt - e0), 64'd1);
    check("t3_no_h_err", 64'(h_err_cnt - l0), 64'd0);
    check("t3_v_meas_back", 64'(v_total_meas), 64'(V));

    // hsync stuck high: single timeout pulse
    e0 = h_err_cnt;
    hs_force = 1;
    repeat (1250) @(posedge clk);
    @(negedge clk);
    check("t4_h_err_once", 64'(h_err_cnt - e0), 64'd1);
    check("t4_locked_drop", 64'(locked), 64'd0);
    hs_force = 0;

    // asynchronous reset mid-frame
    repeat (300) @(posedge clk);
    #3 rst = 1'b0;
    chk_pv = 0; chk_xy = 0;
    #1;
    check("t5_reset_outputs", 64'({x_out, y_out, pix_valid, line_start, frame_start,
                                   h_total_meas, v_total_meas, h_err, v_err, locked}), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    e0 = h_err_cnt;
    wait_hfalls(1, "t5_hfall1_timeout");
    repeat (4) @(negedge clk);
    check("t5_first_fall_no_err", 64'(h_err_cnt - e0), 64'd0);
    chk_pv = 1;
    wait_hfalls(1, "t5_hfall2_timeout");
    repeat (4) @(negedge clk);
    check("t5_h_meas", 64'(h_total_meas), 64'(H));
    check("t5_no_err", 64'(h_err_cnt - e0), 64'd0);
    wait_vfalls(1, "t5_vfall_timeout");
    repeat (3) @(negedge clk);
    chk_xy = 1;
    wait_vfalls(1, "t5_vfall2_timeout");

    // video_on stuck high: x saturates, one line_start
    for (int i = 0; i < 2 * H && !(hc >= H_VIS + 2 && hc < H - 4); i++) @(posedge clk);
    chk_xy = 0;
    l0 = ls_cnt;
    vid_force = 1;
    repeat (1100) @(posedge clk);
    @(negedge clk);
    check("t6_x_sat", 64'(x_out), 64'd1023);
    check("t6_pix_valid", 64'(pix_valid), 64'd1);
    check("t6_line_start_once", 64'(ls_cnt - l0), 64'd1);
    vid_force = 0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
